// File: rtl/controle_multiciclo_param_if.sv
// Control bundle between the multicycle controller (master) and the datapath (slave).
// md_start/md_done: md_start is a one-cycle request pulse; md_done is a one-cycle completion pulse
// from the mult/div unit; there is no backpressure, and a request stays outstanding until md_done or timeout.
interface controle_multiciclo_param_if;
  logic [5:0] flags;
  logic [5:0] OPCODE;
  logic [5:0] FUNCT;
  logic       md_done;
  logic [6:0] can_write;
  logic [1:0] PC_source;
  logic       M_MEM_Adress;
  logic       M_ULAA;
  logic [1:0] M_ULAB;
  logic [1:0] M_REG_adress;
  logic [2:0] M_REG_data;
  logic [2:0] ULA_op;
  logic       md_start;
  logic       md_op;
  logic       reset_out;

  modport master (
    input  flags, OPCODE, FUNCT, md_done,
    output can_write, PC_source, M_MEM_Adress, M_ULAA, M_ULAB, M_REG_adress,
           M_REG_data, ULA_op, md_start, md_op, reset_out
  );

  modport slave (
    output flags, OPCODE, FUNCT, md_done,
    input  can_write, PC_source, M_MEM_Adress, M_ULAA, M_ULAB, M_REG_adress,
           M_REG_data, ULA_op, md_start, md_op, reset_out
  );
endinterface

// File: rtl/controle_multiciclo_param.sv
// Multicycle MIPS control FSM with parametrised memory/ALU latencies, mult/div handshake and exceptions.
// Outputs decode from state, counter, OPCODE and FUNCT; dbg_state exposes the current state.
module controle_multiciclo_param #(
  parameter int MEM_WAIT   = 2,
  parameter int ALU_WAIT   = 1,
  parameter int MD_TIMEOUT = 34
) (
  input  logic                               clk,
  input  logic                               reset,
  controle_multiciclo_param_if.master        bus,
  output logic [4:0]                         dbg_state
);

  localparam int CNT_M1  = (MEM_WAIT + 1 > ALU_WAIT) ? MEM_WAIT + 1 : ALU_WAIT;
  localparam int CNT_TOP = (CNT_M1 > MD_TIMEOUT) ? CNT_M1 : MD_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_TOP + 1);

  localparam logic [CNT_W-1:0] MEM_LAST = CNT_W'(MEM_WAIT);
  localparam logic [CNT_W-1:0] ALU_LAST = CNT_W'(ALU_WAIT - 1);
  localparam logic [CNT_W-1:0] MD_LAST  = CNT_W'(MD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_TOP);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_BLE  = 6'h06;
  localparam logic [5:0] OP_BGT  = 6'h07;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ADDIU= 6'h09;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_HALT = 6'h3F;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_DIV  = 6'h1A;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;

  localparam logic [2:0] ALU_ADD = 3'd1;
  localparam logic [2:0] ALU_SUB = 3'd2;
  localparam logic [2:0] ALU_AND = 3'd3;
  localparam logic [2:0] ALU_CMP = 3'd7;

  typedef enum logic [4:0] {
    S_RESET, S_FETCH, S_DECODE, S_EXEC, S_WB, S_BRANCH, S_BR_CALC, S_BR_WR,
    S_MEM_ADDR, S_MEM_RD, S_LW_WB, S_MEM_WR, S_LUI, S_LINK, S_JUMP,
    S_MD_START, S_MD_WAIT, S_EXCEPT
  } state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] counter;

  logic [6:0] cw;
  logic [1:0] pcs;
  logic       ma, ua, ms, mo, rst_o;
  logic [1:0] ub, ra;
  logic [2:0] rd, op;

  logic is_r, r_alu, ovf_chk, md_div, br_taken;
  logic unused_flags;

  assign is_r     = (bus.OPCODE == OP_R);
  assign r_alu    = is_r && (bus.FUNCT == FN_ADD || bus.FUNCT == FN_SUB || bus.FUNCT == FN_AND);
  // ADDIU never traps; signed add/sub and ADDI do.
  assign ovf_chk  = (is_r && (bus.FUNCT == FN_ADD || bus.FUNCT == FN_SUB)) || (bus.OPCODE == OP_ADDI);
  assign md_div   = (bus.FUNCT == FN_DIV);
  assign unused_flags = ^{bus.flags[4], bus.flags[2], bus.flags[1]};

  always_comb begin
    br_taken = 1'b0;
    case (bus.OPCODE[1:0])
      2'b00:   br_taken = bus.flags[3];
      2'b01:   br_taken = !bus.flags[3];
      2'b10:   br_taken = !bus.flags[5];
      default: br_taken = bus.flags[5];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_RESET;
      counter <= '0;
    end else begin
      state <= next_state;
      if (next_state != state)   counter <= '0;
      else if (counter != CNT_SAT) counter <= counter + 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    cw    = '0;
    pcs   = '0;
    ma    = 1'b0;
    ua    = 1'b0;
    ub    = '0;
    ra    = '0;
    rd    = '0;
    op    = '0;
    ms    = 1'b0;
    mo    = 1'b0;
    rst_o = 1'b0;
    case (state)
      S_RESET: begin
        rst_o      = 1'b1;
        next_state = S_FETCH;
      end
      S_FETCH: begin
        ub = 2'd1;
        op = ALU_ADD;
        if (counter == MEM_LAST) begin
          cw[2]      = 1'b1;
          cw[5]      = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        cw[0] = 1'b1;
        cw[4] = 1'b1;
        case (bus.OPCODE)
          OP_HALT:            next_state = S_RESET;
          OP_R: begin
            if (r_alu)                                             next_state = S_EXEC;
            else if (bus.FUNCT == FN_JR)                           next_state = S_JUMP;
            else if (bus.FUNCT == FN_MULT || bus.FUNCT == FN_DIV)  next_state = S_MD_START;
            else                                                   next_state = S_EXCEPT;
          end
          OP_ADDI, OP_ADDIU:                   next_state = S_EXEC;
          OP_BEQ, OP_BNE, OP_BLE, OP_BGT:      next_state = S_BRANCH;
          OP_LW, OP_SW:                        next_state = S_MEM_ADDR;
          OP_LUI:                              next_state = S_LUI;
          OP_J:                                next_state = S_JUMP;
          OP_JAL:                              next_state = S_LINK;
          default:                             next_state = S_EXCEPT;
        endcase
      end
      S_EXEC: begin
        ua = 1'b1;
        ub = is_r ? 2'd0 : 2'd2;
        if (is_r && bus.FUNCT == FN_SUB)      op = ALU_SUB;
        else if (is_r && bus.FUNCT == FN_AND) op = ALU_AND;
        else                                  op = ALU_ADD;
        if (counter == ALU_LAST) begin
          cw[5]      = 1'b1;
          next_state = (bus.flags[0] && ovf_chk) ? S_EXCEPT : S_WB;
        end
      end
      S_WB: begin
        cw[3]      = 1'b1;
        rd         = 3'd1;
        ra         = is_r ? 2'd1 : 2'd0;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        ua = 1'b1;
        op = ALU_CMP;
        if (counter == ALU_LAST) next_state = br_taken ? S_BR_CALC : S_FETCH;
      end
      S_BR_CALC: begin
        ub         = 2'd3;
        op         = ALU_ADD;
        cw[5]      = 1'b1;
        next_state = S_BR_WR;
      end
      S_BR_WR: begin
        cw[0]      = 1'b1;
        next_state = S_FETCH;
      end
      S_MEM_ADDR: begin
        ua = 1'b1;
        ub = 2'd2;
        op = ALU_ADD;
        if (counter == ALU_LAST) begin
          cw[5]      = 1'b1;
          next_state = (bus.OPCODE == OP_LW) ? S_MEM_RD : S_MEM_WR;
        end
      end
      S_MEM_RD: begin
        ma = 1'b1;
        if (counter == MEM_LAST) next_state = S_LW_WB;
      end
      S_LW_WB: begin
        cw[3]      = 1'b1;
        rd         = 3'd2;
        next_state = S_FETCH;
      end
      S_MEM_WR: begin
        ma         = 1'b1;
        cw[1]      = 1'b1;
        next_state = S_FETCH;
      end
      S_LUI: begin
        cw[3]      = 1'b1;
        rd         = 3'd6;
        next_state = S_FETCH;
      end
      S_LINK: begin
        cw[3]      = 1'b1;
        ra         = 2'd2;
        rd         = 3'd3;
        next_state = S_JUMP;
      end
      S_JUMP: begin
        cw[0]      = 1'b1;
        pcs        = is_r ? 2'd2 : 2'd1;
        next_state = S_FETCH;
      end
      S_MD_START: begin
        ms         = 1'b1;
        mo         = md_div;
        next_state = S_MD_WAIT;
      end
      S_MD_WAIT: begin
        mo = md_div;
        // Completion beats the timeout when both land on the same cycle.
        if (bus.md_done)             next_state = S_FETCH;
        else if (counter == MD_LAST) next_state = S_EXCEPT;
      end
      S_EXCEPT: begin
        ub         = 2'd1;
        op         = ALU_SUB;
        cw[6]      = 1'b1;
        cw[0]      = 1'b1;
        pcs        = 2'd3;
        next_state = S_FETCH;
      end
      default: next_state = S_RESET;
    endcase
  end

  // Reset gates the decode so an interrupted instruction issues no write in the reset cycle.
  assign bus.can_write    = reset ? '0 : cw;
  assign bus.PC_source    = reset ? '0 : pcs;
  assign bus.M_MEM_Adress = reset ? 1'b0 : ma;
  assign bus.M_ULAA       = reset ? 1'b0 : ua;
  assign bus.M_ULAB       = reset ? '0 : ub;
  assign bus.M_REG_adress = reset ? '0 : ra;
  assign bus.M_REG_data   = reset ? '0 : rd;
  assign bus.ULA_op       = reset ? '0 : op;
  assign bus.md_start     = reset ? 1'b0 : ms;
  assign bus.md_op        = reset ? 1'b0 : mo;
  assign bus.reset_out    = reset | rst_o;
  assign dbg_state        = state;

endmodule
